// File: rtl/jstk2_spi_responder.sv
// SPI mode-0 slave emulating a PMOD JSTK2 joystick: reports X/Y/buttons in
// 5-byte frames and decodes the set-LED command from the master's MOSI bytes.
module jstk2_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FRAME_BYTES = 5,
    parameter logic [7:0]  CMD_SET_LED = 8'h84
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CS_n,
    input  logic       SCK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [7:0] buttons,
    output logic [7:0] led_r,
    output logic [7:0] led_g,
    output logic [7:0] led_b,
    output logic       led_update,
    output logic       frame_done,
    output logic       frame_abort
);

    localparam int unsigned IDX_W = $clog2(FRAME_BYTES + 2);
    localparam int unsigned SET_W = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [IDX_W-1:0] FRAME_IDX = IDX_W'(FRAME_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_BYTES + 1);
    localparam logic [SET_W-1:0] SETTLE_MAX = SET_W'(SYNC_STAGES);

    typedef enum logic [1:0] {StWaitIdle, StIdle, StActive} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
    logic                   cs_prev_q, sck_prev_q;
    logic                   cs_s, sck_s, mosi_s;
    logic                   cs_fall, cs_rise, sck_rise, sck_fall;
    logic [SET_W-1:0]       settle_q, settle_d;

    logic [9:0]       snap_x_q, snap_y_q;
    logic [7:0]       snap_btn_q;
    logic [7:0]       tx_shift_q, rx_shift_q, rx_byte;
    logic [2:0]       bit_cnt_q;
    logic [IDX_W-1:0] byte_idx_q;
    logic [7:0]       cmd_q, stage_r_q, stage_g_q, stage_b_q;
    logic [7:0]       led_r_q, led_g_q, led_b_q;
    logic             miso_q, led_update_q, frame_done_q, frame_abort_q;

    // Byte the master reads at a given frame index; past the frame it reads zero.
    function automatic logic [7:0] tx_byte(input logic [IDX_W-1:0] idx, input logic [9:0] x,
                                           input logic [9:0] y, input logic [7:0] b);
        int unsigned i;
        i = 32'(idx);
        if (i >= FRAME_BYTES) return 8'h00;
        case (i)
            0:       return x[7:0];
            1:       return {6'b0, x[9:8]};
            2:       return y[7:0];
            3:       return {6'b0, y[9:8]};
            4:       return b;
            default: return 8'h00;
        endcase
    endfunction

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign cs_fall  = cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign sck_rise = ~sck_prev_q & sck_s;
    assign sck_fall = sck_prev_q & ~sck_s;
    assign rx_byte  = {rx_shift_q[6:0], mosi_s};

    // Synchronize SPI pins and keep previous values for edge detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cs_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sck_prev_q  <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS_n};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            cs_prev_q   <= cs_s;
            sck_prev_q  <= sck_s;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= StWaitIdle;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // Next state; WAIT_IDLE needs CS_n high after the synchronizer has flushed
    // real pin values, so a frame already in progress is never joined.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            StWaitIdle: begin
                if (!cs_s) begin
                    settle_d = '0;
                end else if (settle_q == SETTLE_MAX) begin
                    state_d  = StIdle;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StIdle:   if (cs_fall) state_d = StActive;
            StActive: if (cs_rise) state_d = StIdle;
            default:  state_d = StWaitIdle;
        endcase
    end

    // Frame datapath: snapshot, shift registers, command decode and pulses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            snap_x_q      <= '0;
            snap_y_q      <= '0;
            snap_btn_q    <= '0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            bit_cnt_q     <= '0;
            byte_idx_q    <= '0;
            cmd_q         <= '0;
            stage_r_q     <= '0;
            stage_g_q     <= '0;
            stage_b_q     <= '0;
            led_r_q       <= '0;
            led_g_q       <= '0;
            led_b_q       <= '0;
            miso_q        <= 1'b0;
            led_update_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            led_update_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            if (state_q == StIdle && cs_fall) begin
                snap_x_q   <= x_pos;
                snap_y_q   <= y_pos;
                snap_btn_q <= buttons;
                tx_shift_q <= x_pos[7:0];
                miso_q     <= x_pos[7];
                bit_cnt_q  <= '0;
                byte_idx_q <= '0;
                cmd_q      <= '0;
            end else if (state_q == StActive) begin
                if (cs_rise) begin
                    // CS_n rise wins over any SCK edge seen in the same cycle.
                    miso_q <= 1'b0;
                    if (byte_idx_q >= FRAME_IDX && bit_cnt_q == 3'd0) begin
                        frame_done_q <= 1'b1;
                        if (cmd_q == CMD_SET_LED) begin
                            led_r_q      <= stage_r_q;
                            led_g_q      <= stage_g_q;
                            led_b_q      <= stage_b_q;
                            led_update_q <= 1'b1;
                        end
                    end else begin
                        frame_abort_q <= 1'b1;
                    end
                end else if (sck_rise) begin
                    rx_shift_q <= rx_byte;
                    bit_cnt_q  <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        case (32'(byte_idx_q))
                            0:       cmd_q     <= rx_byte;
                            1:       stage_r_q <= rx_byte;
                            2:       stage_g_q <= rx_byte;
                            3:       stage_b_q <= rx_byte;
                            default: ;
                        endcase
                        if (byte_idx_q != LAST_IDX) byte_idx_q <= byte_idx_q + 1'b1;
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        tx_shift_q <= tx_byte(byte_idx_q, snap_x_q, snap_y_q, snap_btn_q);
                        miso_q <= tx_byte(byte_idx_q, snap_x_q, snap_y_q, snap_btn_q) >> 7 != 8'h00;
                    end else begin
                        tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                        miso_q     <= tx_shift_q[6];
                    end
                end
            end else begin
                miso_q <= 1'b0;
            end
        end
    end

    assign MISO        = miso_q;
    assign led_r       = led_r_q;
    assign led_g       = led_g_q;
    assign led_b       = led_b_q;
    assign led_update  = led_update_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: doc/jstk2_spi_responder.md
Name: jstk2_spi_responder

Overview:
SPI mode-0 slave that emulates the PMOD JSTK2 joystick module. It answers the 5-byte frames issued by the joystick SPI master with X/Y/button data supplied on its inputs, and decodes the LED-colour command carried in the master's MOSI bytes. It is used as the closed-loop stimulus source for the joystick reader in simulation. It is also used on a second board as a joystick stand-in driven by switches or counters.

Parameters:
SYNC_STAGES, 2, synchronizer flops on CS_n, SCK and MOSI (minimum 2)
FRAME_BYTES, 5, bytes per complete frame
CMD_SET_LED, 8'h84, command byte that makes bytes 1..3 an RGB LED value

Ports:
CLK  input  1  system clock; must be at least 8x the SCK frequency
RST_N  input  1  asynchronous active-low reset
CS_n  input  1  SPI chip select from master, active low
SCK  input  1  SPI clock from master, idle low
MOSI  input  1  SPI data from master
MISO  output  1  SPI data to master
x_pos  input  10  X value to report
y_pos  input  10  Y value to report
buttons  input  8  button byte to report
led_r, led_g, led_b  output  8 each  last accepted LED colour
led_update  output  1  one-CLK pulse when led_* change
frame_done  output  1  one-CLK pulse on a complete frame
frame_abort  output  1  one-CLK pulse on a short frame

Behaviour:
- Reset values: MISO=0, led_r/g/b=0, all pulses=0, synchronizers=idle (CS_n=1, SCK=0), state=WAIT_IDLE.
- All SPI inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized values. Nothing is sampled combinationally from the pins.
- States:
  - WAIT_IDLE: waits for synced CS_n=1, then goes to IDLE. This prevents joining a frame in progress after reset or power-up.
  - IDLE: MISO=0. A CS_n falling edge goes to ACTIVE.
  - ACTIVE: described below. A CS_n rising edge goes to IDLE.
- Frame start (CS_n falling): snapshot x_pos, y_pos and buttons into tx registers. Set byte_idx=0 and bit_cnt=0. Present bit 7 of byte 0 on MISO on the next CLK.
- Tx byte order, MSB first:
  - byte 0: x[7:0]
  - byte 1: {6'b0, x[9:8]}
  - byte 2: y[7:0]
  - byte 3: {6'b0, y[9:8]}
  - byte 4: buttons
  - any byte at index >= FRAME_BYTES: 8'h00
- SCK rising (synced): shift MOSI into rx_shift and increment bit_cnt. On the 8th rising edge the rx byte is complete:
  - byte_idx 0 goes to cmd; byte_idx 1..3 go to the r/g/b staging registers.
  - byte_idx increments and saturates at FRAME_BYTES+1; bit_cnt returns to 0.
- SCK falling (synced): shift the tx register left and drive the new MSB on MISO. If bit_cnt=0 (byte boundary), load the byte at byte_idx and drive its bit 7.
- MISO latency: MISO changes SYNC_STAGES+1 CLK cycles after an SCK falling edge at the pin. With CLK >= 8x SCK it is stable before the next rising edge.
- Frame end (CS_n rising):
  - If byte_idx >= FRAME_BYTES and bit_cnt=0: pulse frame_done. If cmd==CMD_SET_LED, copy the staging registers to led_r/g/b on the same cycle and pulse led_update.
  - Otherwise (short frame, or a partial byte pending): pulse frame_abort; led_* unchanged; no led_update.
  - Go to IDLE; MISO=0 on the next CLK.
- Extra bytes beyond FRAME_BYTES read 8'h00. They do not alter cmd or the staging registers, and the frame still counts as done if it ends on a byte boundary.
- The snapshot is taken only at frame start. Input changes during a frame do not affect the bytes in flight.
- SCK edges while CS_n is high are ignored.
- Simultaneous CS_n rise and SCK edge in the same synced cycle: CS_n takes priority and the SCK edge is dropped.
- Asynchronous reset mid-frame: all outputs return to their reset values immediately. The block re-enters via WAIT_IDLE and sees no stale bytes.

Test Plan:
- x_pos=10'd830, y_pos=10'd228, buttons=8'h03, master sends cmd 8'h00 + 4 dummy bytes at SCK=1 MHz, CLK=12 MHz -> master receives 3E 03 E4 00 03; frame_done pulses once; led_update stays 0.
- Master sends 84 FF 80 10 00 -> led_r=FF, led_g=80, led_b=10 one cycle after CS_n rises; led_update and frame_done each pulse once.
- Master deasserts CS_n after 3 bytes of an 84 frame -> frame_abort pulses; led_* keep their previous values; no led_update.
- x_pos changes from 512 to 700 after byte 0 has shifted -> byte 1 still reads 02 (from 512); the next frame reads BC 02.
- Assert RST_N low mid-byte 2 while CS_n stays low, then release -> MISO=0 and no response until CS_n goes high then low; the next frame returns correct data.
- Master clocks 7 bytes -> bytes 5 and 6 read 00; frame_done pulses; the LED command decode is unaffected.
